// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: fetch FSM state encoding, PC step and target alignment.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INCR = 32'd4;

  // Redirect targets are byte addresses; fetch is always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: branch over jump (older instruction wins), redirect over stall.
module pc_next_mux
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic        redirect
);

  always_comb begin
    next_pc  = pc + PC_INCR;
    redirect = 1'b0;
    if (branch) begin
      next_pc  = align_word(branch_target);
      redirect = 1'b1;
    end else if (jump) begin
      next_pc  = align_word(jump_target);
      redirect = 1'b1;
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: streams a program into instruction memory, then runs the PC until halted.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_valid,
  input  logic [31:0]                   load_data,
  input  logic                          load_last,
  output logic                          load_ready,
  output logic                          imem_we,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
  output logic [31:0]                   imem_wdata,
  input  logic                          branch,
  input  logic                          jump,
  input  logic [31:0]                   branch_target,
  input  logic [31:0]                   jump_target,
  input  logic                          stall,
  input  logic                          halt_req,
  output logic [31:0]                   pc,
  output logic                          fetch_en,
  output logic                          flush
);

  localparam int              AW        = $clog2(IMEM_WORDS);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(IMEM_WORDS - 1);

  fetch_state_e  state;
  logic [AW-1:0] word_cnt;
  logic [31:0]   next_pc;
  logic          redirect;

  pc_next_mux u_pc_next_mux (
    .pc            (pc),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  assign load_ready = (state == ST_LOAD);
  assign imem_we    = load_valid && (state == ST_LOAD);
  assign imem_waddr = word_cnt;
  assign imem_wdata = load_data;
  assign fetch_en   = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_LOAD;
      pc       <= RESET_PC;
      word_cnt <= '0;
      flush    <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (load_valid) begin
            // Filling the last slot ends the load even without load_last, so no write ever wraps.
            if (load_last || (word_cnt == LAST_ADDR)) begin
              state    <= ST_RUN;
              word_cnt <= '0;
              pc       <= RESET_PC;
            end else begin
              word_cnt <= word_cnt + AW'(1);
            end
          end
        end
        ST_RUN: begin
          pc    <= next_pc;
          flush <= redirect;
          if (halt_req) state <= ST_HALT;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: load, run, redirect, stall, halt and reset scenarios.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        branch;
  logic        jump;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        stall;
  logic        halt_req;
  logic [31:0] pc;
  logic        fetch_en;
  logic        flush;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .branch        (branch),
    .jump          (jump),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .stall         (stall),
    .halt_req      (halt_req),
    .pc            (pc),
    .fetch_en      (fetch_en),
    .flush         (flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_run();
    branch = 1'b0; jump = 1'b0; stall = 1'b0; halt_req = 1'b0;
    branch_target = '0; jump_target = '0;
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    clear_run();
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_fetch_en", {31'b0, fetch_en}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_load_ready", {31'b0, load_ready}, 32'd1);
    check("rst_imem_we", {31'b0, imem_we}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Three-word load, last on C
    load_valid = 1'b1; load_data = 32'hAAAA_0001; load_last = 1'b0;
    #1;
    check("ld_a_we", {31'b0, imem_we}, 32'd1);
    check("ld_a_addr", {26'b0, imem_waddr}, 32'd0);
    check("ld_a_data", imem_wdata, 32'hAAAA_0001);
    tick();
    load_data = 32'hBBBB_0002;
    #1;
    check("ld_b_addr", {26'b0, imem_waddr}, 32'd1);
    check("ld_b_data", imem_wdata, 32'hBBBB_0002);
    tick();
    load_data = 32'hCCCC_0003; load_last = 1'b1;
    #1;
    check("ld_c_addr", {26'b0, imem_waddr}, 32'd2);
    check("ld_c_we", {31'b0, imem_we}, 32'd1);
    tick();
    check("run_fetch_en", {31'b0, fetch_en}, 32'd1);
    check("run_pc0", pc, 32'h0);
    check("run_load_ready", {31'b0, load_ready}, 32'd0);
    check("run_we_blocked", {31'b0, imem_we}, 32'd0);
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    check("run_pc4", pc, 32'h4);
    tick();
    check("run_pc8", pc, 32'h8);
    tick();
    tick();
    check("run_pc10", pc, 32'h10);

    // Branch and jump together: branch wins
    branch = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h80;
    tick();
    clear_run();
    check("br_over_jmp_pc", pc, 32'h40);
    check("br_flush_hi", {31'b0, flush}, 32'd1);
    tick();
    check("br_flush_lo", {31'b0, flush}, 32'd0);
    check("br_pc44", pc, 32'h44);

    // Stall for three cycles at 0x20
    jump = 1'b1; jump_target = 32'h20;
    tick();
    clear_run();
    check("jmp_pc20", pc, 32'h20);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", pc, 32'h20);
      check("stall_no_flush", {31'b0, flush}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("stall_release", pc, 32'h24);
    stall = 1'b1; jump = 1'b1; jump_target = 32'h103;
    tick();
    clear_run();
    check("jmp_over_stall_pc", pc, 32'h100);
    check("jmp_over_stall_flush", {31'b0, flush}, 32'd1);

    // PC wrap modulo 2^32
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    tick();
    clear_run();
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_post", pc, 32'h0);

    // Halt with branch in the same cycle
    halt_req = 1'b1; branch = 1'b1; branch_target = 32'h60;
    tick();
    clear_run();
    check("halt_pc", pc, 32'h60);
    check("halt_fetch_en", {31'b0, fetch_en}, 32'd0);
    check("halt_flush", {31'b0, flush}, 32'd1);
    branch = 1'b1; branch_target = 32'h200; jump = 1'b1; jump_target = 32'h300;
    tick();
    check("halt_ignore_br", pc, 32'h60);
    check("halt_no_flush", {31'b0, flush}, 32'd0);
    check("halt_fetch_en2", {31'b0, fetch_en}, 32'd0);
    tick();
    check("halt_still", pc, 32'h60);
    clear_run();
    load_valid = 1'b1;
    #1;
    check("halt_no_we", {31'b0, imem_we}, 32'd0);
    check("halt_load_ready", {31'b0, load_ready}, 32'd0);
    load_valid = 1'b0;

    // Reset mid-load restarts at address 0
    rst = 1'b1;
    #1;
    check("rst2_pc", pc, 32'h0);
    check("rst2_fetch_en", {31'b0, fetch_en}, 32'd0);
    check("rst2_load_ready", {31'b0, load_ready}, 32'd1);
    tick();
    rst = 1'b0;
    load_valid = 1'b1; load_data = 32'h1111_0000; load_last = 1'b0;
    tick();
    load_data = 32'h2222_0000;
    #1;
    check("mid_addr1", {26'b0, imem_waddr}, 32'd1);
    tick();
    load_valid = 1'b0;
    #1;
    check("mid_addr2", {26'b0, imem_waddr}, 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_addr", {26'b0, imem_waddr}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    load_valid = 1'b1; load_data = 32'h3333_0000; load_last = 1'b1;
    #1;
    check("reload_addr0", {26'b0, imem_waddr}, 32'd0);
    check("reload_we", {31'b0, imem_we}, 32'd1);
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    check("reload_run", {31'b0, fetch_en}, 32'd1);
    check("reload_pc", pc, 32'h0);

    // Full-depth stream without load_last
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1; load_data = 32'h5000_0000 + i; load_last = 1'b0;
      #1;
      check("full_addr", {26'b0, imem_waddr}, i);
      check("full_ready", {31'b0, load_ready}, 32'd1);
      tick();
    end
    #1;
    check("full_ready_low", {31'b0, load_ready}, 32'd0);
    check("full_no_wrap_we", {31'b0, imem_we}, 32'd0);
    check("full_run", {31'b0, fetch_en}, 32'd1);
    check("full_pc", pc, 32'h0);
    load_valid = 1'b0;
    tick();
    check("full_pc4", pc, 32'h4);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
